// File: rtl/pulse_sequencer_pkg.sv
// ============================================================================
// Module : pulse_sequencer_pkg
// Brief  : Shared defaults, FSM state encoding and helpers for pulse_sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pulse_sequencer_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    DONE_ST = 2'b10
  } seqState_t;

  // Number of RUN cycles for a given repeat value.
  function automatic int runLength(input int width, input int repeatVal);
    return width * (repeatVal + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pulse_sequencer_if.sv
// ============================================================================
// Module : pulse_sequencer_if
// Brief  : Start handshake, abort and status bundle of the pulse sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface pulse_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);

  logic             startValid;
  logic             startReady;
  logic [WIDTH-1:0] pattern;
  logic [CNT_W-1:0] repeatCnt;
  logic             abort;
  logic             busy;
  logic             pulseOut;
  logic             done;

  modport master (
    output startValid,
    output pattern,
    output repeatCnt,
    output abort,
    input  startReady,
    input  busy,
    input  pulseOut,
    input  done
  );

  modport slave (
    input  startValid,
    input  pattern,
    input  repeatCnt,
    input  abort,
    output startReady,
    output busy,
    output pulseOut,
    output done
  );

endinterface

`default_nettype wire

// File: rtl/pulse_sequencer_rotator.sv
// ============================================================================
// Module : pulse_rotator
// Brief  : WIDTH-bit rotate register with parallel load (priority) and enable.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pulse_rotator #(
  parameter int WIDTH = 8
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             i_load,
  input  wire logic             i_en,
  input  wire logic [WIDTH-1:0] i_pattern,
  output logic                  o_msb
);

  logic [WIDTH-1:0] r_q;

  // Rotation moves each bit up one place and feeds the MSB back into bit 0,
  // so the pattern is seen MSB-first on o_msb.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_pattern;
    end else if (i_en) begin
      r_q <= {r_q[WIDTH-2:0], r_q[WIDTH-1]};
    end
  end

  assign o_msb = r_q[WIDTH-1];

endmodule

`default_nettype wire

// File: rtl/pulse_sequencer.sv
// ============================================================================
// Module : pulse_sequencer
// Brief  : Load/rotate pulse generator controller: FSM, counters, output gating.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pulse_sequencer
  import pulse_sequencer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  pulse_sequencer_if.slave bus
);

  localparam int              c_BW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_BW-1:0] c_LAST = c_BW'(WIDTH - 1);
  localparam logic [c_BW-1:0] c_ONE  = c_BW'(1);

  seqState_t        r_state;
  logic [c_BW-1:0]  r_bitCnt;
  logic [CNT_W-1:0] r_rotCnt;
  logic [CNT_W-1:0] r_repQ;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;

  logic w_accept;
  logic w_lastBit;
  logic w_lastRun;
  logic w_rotEn;
  logic w_msb;

  assign w_accept  = bus.startValid & r_ready;
  assign w_lastBit = (r_bitCnt == c_LAST);
  assign w_lastRun = w_lastBit && (r_rotCnt == r_repQ);
  assign w_rotEn   = (r_state == RUN);

  pulse_rotator #(
    .WIDTH (WIDTH)
  ) u_rotator (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_accept),
    .i_en      (w_rotEn),
    .i_pattern (bus.pattern),
    .o_msb     (w_msb)
  );

  // Status outputs are registered alongside the state so they change on the
  // same edge as the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_bitCnt <= '0;
      r_rotCnt <= '0;
      r_repQ   <= '0;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_state  <= RUN;
            r_repQ   <= bus.repeatCnt;
            r_bitCnt <= '0;
            r_rotCnt <= '0;
            r_ready  <= 1'b0;
            r_busy   <= 1'b1;
          end
        end

        RUN: begin
          if (bus.abort) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
          end else if (w_lastRun) begin
            r_state <= DONE_ST;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else if (w_lastBit) begin
            // rot_cnt never passes rep_q, so REPEAT at its maximum cannot overflow
            r_bitCnt <= '0;
            r_rotCnt <= r_rotCnt + 1'b1;
          end else begin
            r_bitCnt <= r_bitCnt + c_ONE;
          end
        end

        DONE_ST: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_ready <= 1'b1;
        end

        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.startReady = r_ready;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.pulseOut   = w_msb & r_busy;

endmodule

`default_nettype wire
